// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock chamber arbiter: FSM states,
// requester identities and the pump-phase durations.
package airlock_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EVAC     = 3'd1,
        S_PRESS    = 3'd2,
        S_OPEN_OUT = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_OPEN_IN  = 3'd5,
        S_WAIT_IN  = 3'd6
    } state_e;

    typedef enum logic {
        ARRIVE = 1'b0,
        DEPART = 1'b1
    } requester_e;

    localparam int DEFAULT_FILL_SECS  = 7;
    localparam int DEFAULT_DRAIN_SECS = 8;
    localparam int DEFAULT_CNT_W      = 4;

    // A lone requester wins; on a tie the side not served last time wins.
    function automatic requester_e pick_winner(input logic       arrive,
                                               input logic       depart,
                                               input requester_e last);
        if (arrive && !depart) begin
            return ARRIVE;
        end
        if (depart && !arrive) begin
            return DEPART;
        end
        return (last == DEPART) ? ARRIVE : DEPART;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Seconds counter for one pump phase: cleared on phase entry, advanced by the
// once-per-second tick while enabled, flags the tick that completes the phase.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] secs,
    output logic             done
);

    logic [CNT_W-1:0] secs_q;
    logic [CNT_W-1:0] secs_d;
    logic             count_en;

    assign count_en = enable & tick;
    assign done     = count_en & (secs_q == target - CNT_W'(1));

    // The completing tick leaves secs at target-1 so it reads 0..target-1.
    always_comb begin
        secs_d = secs_q;
        if (clear) begin
            secs_d = '0;
        end else if (count_en && !done && (secs_q != {CNT_W{1'b1}})) begin
            secs_d = secs_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            secs_q <= '0;
        end else begin
            secs_q <= secs_d;
        end
    end

    assign secs = secs_q;

endmodule

// File: rtl/airlock_arbiter.sv
// Grants the shared airlock chamber to the arrival or departure sequence and
// steps it through pump and door phases while enforcing the door/pump interlocks.
module airlock_arbiter
    import airlock_pkg::*;
#(
    parameter int FILL_SECS  = DEFAULT_FILL_SECS,
    parameter int DRAIN_SECS = DEFAULT_DRAIN_SECS,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             arrive_req,
    input  logic             depart_req,
    input  logic             outer_closed,
    input  logic             inner_closed,
    output logic             arrive_grant,
    output logic             depart_grant,
    output logic             outer_open_en,
    output logic             inner_open_en,
    output logic             pressurizing,
    output logic             evacuating,
    output logic             pumps_held,
    output logic             chamber_press,
    output logic [CNT_W-1:0] secs,
    output logic [2:0]       state
);

    state_e     state_q, state_d;
    requester_e owner_q, owner_d;
    requester_e last_q, last_d;
    logic       press_q, press_d;

    logic arrive_grant_q, arrive_grant_d;
    logic depart_grant_q, depart_grant_d;
    logic outer_open_en_q, outer_open_en_d;
    logic inner_open_en_q, inner_open_en_d;
    logic pressurizing_q, pressurizing_d;
    logic evacuating_q, evacuating_d;
    logic pumps_held_q, pumps_held_d;

    logic             doors_closed;
    logic             in_pump;
    logic             any_req;
    requester_e       winner;
    logic             stall;
    logic             timer_clear;
    logic             timer_en;
    logic             phase_done;
    logic [CNT_W-1:0] phase_target;
    logic [CNT_W-1:0] timer_secs;

    assign doors_closed = outer_closed & inner_closed;
    assign in_pump      = (state_q == S_EVAC) || (state_q == S_PRESS);
    assign any_req      = arrive_req | depart_req;
    assign winner       = pick_winner(arrive_req, depart_req, last_q);
    assign timer_en     = in_pump & doors_closed;
    assign phase_target = (state_q == S_PRESS) ? CNT_W'(FILL_SECS) : CNT_W'(DRAIN_SECS);
    assign timer_clear  = ((state_d == S_EVAC) || (state_d == S_PRESS)) && (state_d != state_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tick   (tick),
        .target (phase_target),
        .secs   (timer_secs),
        .done   (phase_done)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        press_d = press_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    // Skip the first pump phase when the chamber already matches.
                    if (winner == ARRIVE) begin
                        if (press_q) begin
                            state_d = S_EVAC;
                        end else if (inner_closed) begin
                            state_d = S_OPEN_OUT;
                        end else begin
                            stall = 1'b1;
                        end
                    end else begin
                        if (!press_q) begin
                            state_d = S_PRESS;
                        end else if (outer_closed) begin
                            state_d = S_OPEN_IN;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
            end
            S_EVAC: begin
                if (phase_done) begin
                    press_d = 1'b0;
                    state_d = S_OPEN_OUT;
                end
            end
            S_PRESS: begin
                if (phase_done) begin
                    press_d = 1'b1;
                    state_d = S_OPEN_IN;
                end
            end
            S_OPEN_OUT: begin
                if (!outer_closed) begin
                    state_d = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                if (outer_closed) begin
                    if (owner_q == ARRIVE) begin
                        state_d = S_PRESS;
                    end else begin
                        state_d = S_IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            S_OPEN_IN: begin
                if (!inner_closed) begin
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (inner_closed) begin
                    if (owner_q == ARRIVE) begin
                        state_d = S_IDLE;
                        last_d  = owner_q;
                    end else begin
                        state_d = S_EVAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode the current state, so they follow a state entry by one cycle.
    always_comb begin
        arrive_grant_d  = (state_q != S_IDLE) && (owner_q == ARRIVE);
        depart_grant_d  = (state_q != S_IDLE) && (owner_q == DEPART);
        outer_open_en_d = (state_q == S_OPEN_OUT) || (state_q == S_WAIT_OUT);
        inner_open_en_d = (state_q == S_OPEN_IN) || (state_q == S_WAIT_IN);
        evacuating_d    = (state_q == S_EVAC);
        pressurizing_d  = (state_q == S_PRESS);
        pumps_held_d    = (in_pump && !doors_closed) || stall;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            owner_q         <= ARRIVE;
            last_q          <= DEPART;
            press_q         <= 1'b1;
            arrive_grant_q  <= 1'b0;
            depart_grant_q  <= 1'b0;
            outer_open_en_q <= 1'b0;
            inner_open_en_q <= 1'b0;
            pressurizing_q  <= 1'b0;
            evacuating_q    <= 1'b0;
            pumps_held_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            press_q         <= press_d;
            arrive_grant_q  <= arrive_grant_d;
            depart_grant_q  <= depart_grant_d;
            outer_open_en_q <= outer_open_en_d;
            inner_open_en_q <= inner_open_en_d;
            pressurizing_q  <= pressurizing_d;
            evacuating_q    <= evacuating_d;
            pumps_held_q    <= pumps_held_d;
        end
    end

    assign arrive_grant  = arrive_grant_q;
    assign depart_grant  = depart_grant_q;
    assign outer_open_en = outer_open_en_q;
    assign inner_open_en = inner_open_en_q;
    assign pressurizing  = pressurizing_q;
    assign evacuating    = evacuating_q;
    assign pumps_held    = pumps_held_q;
    assign chamber_press = press_q;
    assign secs          = timer_secs;
    assign state         = state_q;

endmodule
